mux_scan_ctrl: RTL and testbench

Upstream sequencer for the 16:1 bit multiplexer. Drives the mux select through channels 0..NUM_CH-1 and samples the mux output bit for each channel. Assembles the sampled bits into one parallel word and presents it with a valid/ready handshake. Converts a single-bit mux path back into a snapshot of all NUM_CH inputs for downstream logic.

---
 rtl/mux_scan_pkg.sv | 25 ++
 rtl/mux_scan_ctrl_if.sv | 43 ++++
 rtl/mux_scan_ctrl.sv | 107 ++++++++++
 tb/tb_mux_scan_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_pkg
// Description : Shared types and constants for the mux scan controller.
//               Holds the FSM state encoding, the default channel count and
//               select width, and the dwell counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_scan_pkg;

    // Default geometry matches a 16:1 bit multiplexer.
    localparam int NUM_CH_DEF = 16;
    localparam int SEL_W_DEF  = 4;

    // The dwell counter is 3 bits wide, so it covers settle counts 0..7.
    localparam int DWELL_W    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage : mux_scan_pkg
`default_nettype wire

// File: rtl/mux_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_ctrl_if
// Description : Bundles the scan controller's control, mux-loop and output
//               handshake signals.
//   start  : request one scan pass (controller input)
//   cont   : auto-restart after each handshake (controller input)
//   mux_y  : combinational output of the mux (controller input)
//   sel    : registered mux select (controller output)
//   word   : assembled snapshot of all channels (controller output)
//   valid  : word available (controller output)
//   ready  : downstream accepts word (controller input)
//   busy   : pass in progress or word pending (controller output)
//   Modports: master = controller side, slave = environment side.
// Revision    : 1.0 - initial release
// ============================================================================
interface mux_scan_ctrl_if
    import mux_scan_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int SEL_W  = SEL_W_DEF
);
    logic              start;
    logic              cont;
    logic              mux_y;
    logic [SEL_W-1:0]  sel;
    logic [NUM_CH-1:0] word;
    logic              valid;
    logic              ready;
    logic              busy;

    modport master (
        input  start, cont, mux_y, ready,
        output sel, word, valid, busy
    );

    modport slave (
        output start, cont, mux_y, ready,
        input  sel, word, valid, busy
    );

endinterface : mux_scan_ctrl_if
`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_ctrl
// Description : Steps a mux select through channels 0..NUM_CH-1, samples the
//               single-bit mux output once per channel and presents the
//               collected bits as one parallel word on a valid/ready
//               handshake.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : mux_scan_ctrl_if.master (start, cont, mux_y, sel, word,
//            valid, ready, busy)
// Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int SEL_W  = SEL_W_DEF,
    parameter int SETTLE = 0
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    mux_scan_ctrl_if.master bus
);

    localparam logic [SEL_W-1:0]   LAST_SEL   = SEL_W'(NUM_CH - 1);
    localparam logic [DWELL_W-1:0] LAST_DWELL = DWELL_W'(SETTLE);

    state_e              state_q,  state_d;
    logic [SEL_W-1:0]    sel_q,    sel_d;
    logic [DWELL_W-1:0]  dwell_q,  dwell_d;
    logic [NUM_CH-1:0]   shadow_q, shadow_d;
    logic [NUM_CH-1:0]   word_q,   word_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            dwell_q  <= '0;
            shadow_q <= '0;
            word_q   <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            dwell_q  <= dwell_d;
            shadow_q <= shadow_d;
            word_q   <= word_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        dwell_d  = dwell_q;
        shadow_d = shadow_q;
        word_d   = word_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SCAN;
                    sel_d   = '0;
                    dwell_d = '0;
                end
            end

            SCAN: begin
                if (dwell_q == LAST_DWELL) begin
                    shadow_d[sel_q] = bus.mux_y;
                    dwell_d         = '0;
                    if (sel_q == LAST_SEL) begin
                        // Take the updated shadow so the final channel's bit
                        // lands in this pass's word rather than the next one.
                        word_d  = shadow_d;
                        sel_d   = '0;
                        state_d = HOLD;
                    end else begin
                        sel_d   = sel_q + SEL_W'(1);
                    end
                end else begin
                    dwell_d = dwell_q + DWELL_W'(1);
                end
            end

            HOLD: begin
                if (bus.ready) begin
                    state_d = bus.cont ? SCAN : IDLE;
                    sel_d   = '0;
                    dwell_d = '0;
                end
            end

            default: begin
                state_d = IDLE;
                sel_d   = '0;
                dwell_d = '0;
            end
        endcase
    end

    assign bus.sel   = sel_q;
    assign bus.word  = word_q;
    assign bus.valid = (state_q == HOLD);
    assign bus.busy  = (state_q != IDLE);

endmodule : mux_scan_ctrl
`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_scan_ctrl
// Description : Self-checking bench for mux_scan_ctrl. Two controllers
//               (SETTLE=0 and SETTLE=2) each close the loop through a
//               behavioural 16:1 mux. Expected words are queued when a pass
//               is started and compared when the handshake completes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_scan_ctrl;
    import mux_scan_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] mux_in;
    logic [15:0] mux_in2;

    mux_scan_ctrl_if #(.NUM_CH(16), .SEL_W(4)) bus0 ();
    mux_scan_ctrl_if #(.NUM_CH(16), .SEL_W(4)) bus2 ();

    assign bus0.mux_y = mux_in[bus0.sel];
    assign bus2.mux_y = mux_in2[bus2.sel];

    mux_scan_ctrl #(.NUM_CH(16), .SEL_W(4), .SETTLE(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    mux_scan_ctrl #(.NUM_CH(16), .SEL_W(4), .SETTLE(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    int checks = 0;
    int errors = 0;
    int hs0    = 0;
    int hs2    = 0;
    logic [15:0] exp_q  [$];
    logic [15:0] exp2_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: a handshake seen before an edge completes at that edge.
    always @(negedge clk) begin
        if (bus0.valid && bus0.ready) begin
            hs0++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb0_unexpected actual=%h required=none", bus0.word);
            end else begin
                chk("sb0_word", 32'(bus0.word), 32'(exp_q.pop_front()));
            end
        end
        if (bus2.valid && bus2.ready) begin
            hs2++;
            if (exp2_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb2_unexpected actual=%h required=none", bus2.word);
            end else begin
                chk("sb2_word", 32'(bus2.word), 32'(exp2_q.pop_front()));
            end
        end
    end

    // One full pass on the SETTLE=0 controller with ready held high.
    task automatic run_pass0(input logic [15:0] expw, input int exp_lat);
        int n;
        bit sel_ok;
        bus0.ready = 1'b1;
        bus0.start = 1'b1;
        exp_q.push_back(expw);
        step();
        bus0.start = 1'b0;
        chk("accept_busy", 32'(bus0.busy), 32'd1);
        sel_ok = 1'b1;
        n      = 0;
        while (!bus0.valid && n < 200) begin
            if (bus0.sel !== 4'(n)) sel_ok = 1'b0;
            step();
            n++;
        end
        chk("latency", 32'(n), 32'(exp_lat));
        chk("sel_seq", 32'(sel_ok), 32'd1);
        chk("sel_after_pass", 32'(bus0.sel), 32'd0);
        step();
        chk("valid_drop", 32'(bus0.valid), 32'd0);
        chk("busy_idle", 32'(bus0.busy), 32'd0);
    endtask

    typedef struct {
        logic [15:0] pattern;
        logic [15:0] expw;
        int          lat;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int n;
        int hs_before;
        bit ok;

        vecs[0] = '{16'hA5C3, 16'hA5C3, 16};
        vecs[1] = '{16'h0000, 16'h0000, 16};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 16};
        vecs[3] = '{16'h8001, 16'h8001, 16};

        rst_n      = 1'b0;
        mux_in     = 16'h0;
        mux_in2    = 16'h0;
        bus0.start = 1'b0;
        bus0.cont  = 1'b0;
        bus0.ready = 1'b0;
        bus2.start = 1'b0;
        bus2.cont  = 1'b0;
        bus2.ready = 1'b0;
        step();
        step();
        chk("rst_sel", 32'(bus0.sel), 32'd0);
        chk("rst_word", 32'(bus0.word), 32'd0);
        chk("rst_valid", 32'(bus0.valid), 32'd0);
        chk("rst_busy", 32'(bus0.busy), 32'd0);
        rst_n = 1'b1;
        step();

        // Table-driven single passes.
        for (int i = 0; i < 4; i++) begin
            mux_in = vecs[i].pattern;
            run_pass0(vecs[i].expw, vecs[i].lat);
        end
        chk("word_retained", 32'(bus0.word), 32'h8001);

        // Backpressure: word and valid held while ready is low.
        mux_in     = 16'h0001;
        bus0.ready = 1'b0;
        bus0.start = 1'b1;
        exp_q.push_back(16'h0001);
        step();
        bus0.start = 1'b0;
        n = 0;
        while (!bus0.valid && n < 200) begin step(); n++; end
        chk("bp_latency", 32'(n), 32'd16);
        ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (bus0.valid !== 1'b1 || bus0.word !== 16'h0001) ok = 1'b0;
            step();
        end
        chk("bp_hold", 32'(ok), 32'd1);
        bus0.ready = 1'b1;
        step();
        chk("bp_valid_drop", 32'(bus0.valid), 32'd0);
        chk("bp_busy_idle", 32'(bus0.busy), 32'd0);

        // SETTLE=2: each select value dwells 3 cycles, valid after 48 edges.
        mux_in2    = 16'hFFFF;
        step();
        mux_in2    = 16'h8000;
        bus2.ready = 1'b1;
        bus2.start = 1'b1;
        exp2_q.push_back(16'h8000);
        step();
        bus2.start = 1'b0;
        ok = 1'b1;
        n  = 0;
        while (!bus2.valid && n < 300) begin
            if (bus2.sel !== 4'(n / 3)) ok = 1'b0;
            step();
            n++;
        end
        chk("s2_latency", 32'(n), 32'd48);
        chk("s2_sel_dwell", 32'(ok), 32'd1);
        step();
        chk("s2_busy_idle", 32'(bus2.busy), 32'd0);

        // Continuous mode: two passes 17 cycles apart, start held high.
        mux_in     = 16'h1234;
        bus0.cont  = 1'b1;
        bus0.ready = 1'b1;
        bus0.start = 1'b1;
        exp_q.push_back(16'h1234);
        exp_q.push_back(16'hFEDC);
        step();
        n = 0;
        while (!bus0.valid && n < 200) begin step(); n++; end
        chk("cont_first_lat", 32'(n), 32'd16);
        mux_in = 16'hFEDC;
        step();
        chk("cont_gap_valid", 32'(bus0.valid), 32'd0);
        chk("cont_restart_busy", 32'(bus0.busy), 32'd1);
        n = 1;
        while (!bus0.valid && n < 200) begin step(); n++; end
        chk("cont_spacing", 32'(n), 32'd17);
        bus0.start = 1'b0;
        bus0.cont  = 1'b0;
        step();
        chk("cont_end_idle", 32'(bus0.busy), 32'd0);

        // Reset mid-scan at sel=7, then a fresh pass.
        mux_in     = 16'h5A5A;
        bus0.start = 1'b1;
        step();
        bus0.start = 1'b0;
        n = 0;
        while (bus0.sel !== 4'd7 && n < 40) begin step(); n++; end
        chk("mid_reach_sel7", 32'(bus0.sel), 32'd7);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sel", 32'(bus0.sel), 32'd0);
        chk("mid_rst_busy", 32'(bus0.busy), 32'd0);
        chk("mid_rst_word", 32'(bus0.word), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        mux_in = 16'h6C39;
        run_pass0(16'h6C39, 16);

        // start held through SCAN and HOLD: exactly one pass.
        hs_before  = hs0;
        mux_in     = 16'h3C3C;
        bus0.ready = 1'b0;
        bus0.start = 1'b1;
        exp_q.push_back(16'h3C3C);
        step();
        n = 0;
        while (!bus0.valid && n < 200) begin step(); n++; end
        step();
        step();
        step();
        bus0.start = 1'b0;
        bus0.ready = 1'b1;
        step();
        ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (bus0.valid !== 1'b0 || bus0.busy !== 1'b0) ok = 1'b0;
            step();
        end
        chk("start_ignored_quiet", 32'(ok), 32'd1);
        chk("start_ignored_count", 32'(hs0 - hs_before), 32'd1);

        chk("sb0_drained", 32'(exp_q.size()), 32'd0);
        chk("sb2_drained", 32'(exp2_q.size()), 32'd0);
        chk("sb2_count", 32'(hs2), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mux_scan_ctrl
`default_nettype wire
